// File: rtl/meta_issue_queue.sv
// meta_issue_queue: buffers the resource manager's meta-data pulses in a FIFO.
// Each accepted entry gets a gap-free sequence number. Entries that arrive while
// the FIFO is full are dropped and counted. The head is offered downstream
// through a valid/ready handshake.
//
// Handshake: the upstream side has no ready path; a push is any cycle with
// i_meta_data_valid=1. Downstream, a transfer happens on a rising edge where
// o_cmd_valid && i_cmd_ready. o_cmd_valid never depends on i_cmd_ready. The head
// payload and sequence number stay stable while o_cmd_valid && !i_cmd_ready.
// i_cmd_ready has no effect while the queue is empty.

`ifndef NO_OF_TAG
`define NO_OF_TAG 32
`endif
`ifndef MAX_HOST_NUMBER
`define MAX_HOST_NUMBER 8
`endif

module meta_issue_queue #(
  parameter int META_DATA_BIT_WIDTH = 128 - $clog2(`NO_OF_TAG) - $clog2(`MAX_HOST_NUMBER) - 1,
  parameter int DEPTH               = 16,
  parameter int AF_MARGIN           = 2,
  parameter int SEQ_BIT_WIDTH       = 8,
  localparam int CNT_W              = $clog2(DEPTH) + 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [META_DATA_BIT_WIDTH-1:0] i_meta_data,
  input  logic                           i_meta_data_valid,
  output logic [META_DATA_BIT_WIDTH-1:0] o_cmd_data,
  output logic [SEQ_BIT_WIDTH-1:0]       o_cmd_seq,
  output logic                           o_cmd_valid,
  input  logic                           i_cmd_ready,
  output logic [CNT_W-1:0]               o_count,
  output logic                           o_almost_full,
  output logic                           o_overflow,
  output logic [15:0]                    o_drop_cnt,
  input  logic                           i_clr_overflow
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = META_DATA_BIT_WIDTH + SEQ_BIT_WIDTH;

  logic [ENTRY_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [SEQ_BIT_WIDTH-1:0] seq;
  logic                     overflow;
  logic [15:0]              drop_cnt;

  logic                     full;
  logic                     pop;
  logic                     push;
  logic                     drop;
  logic [ENTRY_W-1:0]       head;

  // A full queue still accepts a push when the head leaves in the same cycle,
  // because the freed slot is reused at the tail.
  always_comb begin
    full = (count == CNT_W'(DEPTH));
    pop  = (count != '0) && i_cmd_ready;
    push = i_meta_data_valid && (!full || pop);
    drop = i_meta_data_valid && full && !pop;
  end

  // Storage array. It is cleared on reset so the head outputs are never X.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {i_meta_data, seq};
    end
  end

  // Pointers, occupancy and sequence numbering. Pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      seq    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        seq    <= seq + SEQ_BIT_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Sticky overflow flag and saturating drop counter. A drop beats a clear in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (i_clr_overflow)            drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (i_clr_overflow) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    head          = mem[rd_ptr];
    o_cmd_data    = head[ENTRY_W-1:SEQ_BIT_WIDTH];
    o_cmd_seq     = head[SEQ_BIT_WIDTH-1:0];
    o_cmd_valid   = (count != '0);
    o_count       = count;
    o_almost_full = (count >= CNT_W'(DEPTH - AF_MARGIN));
    o_overflow    = overflow;
    o_drop_cnt    = drop_cnt;
  end

endmodule
